// File: rtl/dbus_ram_responder_pkg.sv
// rtl/dbus_ram_responder_pkg.sv - shared data-bus types and responder state enum
package common;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Byte-lane merge: lanes with strobe set take the new data, others keep old.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                              input logic [63:0] new_word,
                                              input logic [7:0]  strobe);
    logic [63:0] res;
    res = old_word;
    for (int i = 0; i < 8; i++) begin
      if (strobe[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dbus_ram_responder_byte_ram.sv
// rtl/dbus_ram_responder_byte_ram.sv - MEM_WORDS x 64 array, registered read, byte-strobed write
module byte_ram
  import common::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             re_i,
  input  logic             rzero_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [63:0]      rdata_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [7:0]       wstrb_i,
  input  logic [63:0]      wdata_i
);

  logic [63:0] mem_q [MEM_WORDS];
  logic [63:0] rdata_q;

  // The array itself is never reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= merge_bytes(mem_q[waddr_i], wdata_i, wstrb_i);
    end
  end

  // Read register holds between loads; rzero_i substitutes 0 for out-of-range reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? 64'd0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_ram_responder.sv
// rtl/dbus_ram_responder.sv - fixed-latency data-bus RAM responder (FSM, request regs, range decode)
module dbus_ram_responder
  import common::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [63:0] BASE      = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int          IDX_W    = $clog2(MEM_WORDS);
  localparam logic [63:0] SPAN     = 64'(MEM_WORDS) << 3;
  localparam logic [3:0]  CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dbus_ram_responder: LATENCY out of range 1..15");
  end

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] data_q, data_d;

  logic [63:0]      sel_addr;
  logic [63:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic             ram_re;
  logic             ram_we;
  logic [63:0]      ram_rdata;
  logic             unused_size;

  assign unused_size = ^dreq.size;

  // In IDLE the only read that can start is the LATENCY=1 case, which must
  // decode the live address; every other decode uses the latched one.
  assign sel_addr = (state_q == IDLE) ? dreq.addr : addr_q;
  assign offset   = sel_addr - BASE;
  assign in_range = (sel_addr >= BASE) && (offset < SPAN);
  assign word_idx = offset[IDX_W+2:3];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          addr_d   = dreq.addr;
          strobe_d = dreq.strobe;
          data_d   = dreq.data;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
    end
  end

  // Read happens on entry to RESP, write at the edge leaving it, so the
  // response always carries the word as it stood before this request's write.
  assign ram_re = (state_d == RESP) && (state_q != RESP);
  assign ram_we = (state_q == RESP) && in_range;

  byte_ram #(
    .MEM_WORDS(MEM_WORDS)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .re_i   (ram_re),
    .rzero_i(!in_range),
    .raddr_i(word_idx),
    .rdata_o(ram_rdata),
    .we_i   (ram_we),
    .waddr_i(word_idx),
    .wstrb_i(strobe_q),
    .wdata_i(data_q)
  );

  assign dresp.addr_ok = (state_q == RESP);
  assign dresp.data_ok = (state_q == RESP);
  assign dresp.data    = ram_rdata;

endmodule

// File: tb/tb_dbus_ram_responder.sv
// tb/tb_dbus_ram_responder.sv - scoreboard bench over three responder configurations
module tb_dbus_ram_responder;
  import common::*;

  localparam logic [63:0] BASE = 64'h8000_0000;

  typedef struct {
    int          u;
    int          cyc;
    logic        chk;
    logic [63:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst [3];
  dbus_req_t  req [3];
  dbus_resp_t resp [3];
  int         lat [3] = '{2, 4, 1};
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  exp_t       sb [$];
  exp_t       mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_ram_responder #(.MEM_WORDS(1024), .BASE(BASE), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(rst[0]), .dreq(req[0]), .dresp(resp[0]));
  dbus_ram_responder #(.MEM_WORDS(64), .BASE(BASE), .LATENCY(4)) u_dut1 (
    .clk(clk), .reset(rst[1]), .dreq(req[1]), .dresp(resp[1]));
  dbus_ram_responder #(.MEM_WORDS(64), .BASE(BASE), .LATENCY(1)) u_dut2 (
    .clk(clk), .reset(rst[2]), .dreq(req[2]), .dresp(resp[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      check($sformatf("addr_ok_eq_data_ok%0d", u), 64'(resp[u].addr_ok), 64'(resp[u].data_ok));
      if (resp[u].data_ok === 1'b1) begin
        if (sb.size() == 0) begin
          check($sformatf("spurious_resp%0d", u), 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_unit", 64'(u), 64'(mon_e.u));
          check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
          if (mon_e.chk) check($sformatf("resp_data%0d", u), resp[u].data, mon_e.data);
        end
      end
    end
  end

  task automatic do_req(input int u, input logic [63:0] addr, input logic [7:0] strb,
                        input logic [63:0] wdata, input logic chk, input logic [63:0] exp);
    @(negedge clk);
    req[u].valid  = 1'b1;
    req[u].addr   = addr;
    req[u].size   = MSIZE8;
    req[u].strobe = strb;
    req[u].data   = wdata;
    sb.push_back('{u, cyc + lat[u], chk, exp});
    for (int i = 1; i <= lat[u]; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req[u].addr   = {$urandom, $urandom};
        req[u].data   = {$urandom, $urandom};
        req[u].strobe = 8'($urandom);
        req[u].size   = MSIZE1;
      end
    end
    req[u].valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] model [64];
  bit          written [64];
  int          wl [$];

  initial begin
    int          idx;
    int          r;
    logic [63:0] d;
    logic [63:0] old;
    logic        have;

    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1;
      req[u] = '0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("rst_addr_ok", 64'(resp[u].addr_ok), 64'd0);
      check("rst_data_ok", 64'(resp[u].data_ok), 64'd0);
      check("rst_data", resp[u].data, 64'd0);
    end
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;

    // Full write then read back, partial write, out-of-range read/write (LATENCY=2)
    do_req(0, BASE + 64'h8, 8'hFF, 64'h1122334455667788, 1'b0, 64'd0);
    do_req(0, BASE + 64'h8, 8'h00, 64'h0, 1'b1, 64'h1122334455667788);
    do_req(0, BASE + 64'h8, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b1, 64'h1122334455667788);
    do_req(0, BASE + 64'hC, 8'h00, 64'h0, 1'b1, 64'h11223344_BBBBBBBB);
    do_req(0, BASE, 8'hFF, 64'hCAFE_F00D_0000_0001, 1'b0, 64'd0);
    do_req(0, 64'h0000_1000, 8'h00, 64'h0, 1'b1, 64'd0);
    do_req(0, BASE + 64'h2000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 64'd0);
    do_req(0, BASE, 8'h00, 64'h0, 1'b1, 64'hCAFE_F00D_0000_0001);
    do_req(0, BASE + 64'h8, 8'h00, 64'h0, 1'b1, 64'h11223344_BBBBBBBB);

    // Abort by dropping valid in cycle 2 (LATENCY=4)
    do_req(1, BASE + 64'h10, 8'hFF, 64'h0101_0202_0303_0404, 1'b0, 64'd0);
    do_req(1, BASE + 64'h10, 8'h00, 64'h0, 1'b1, 64'h0101_0202_0303_0404);
    @(negedge clk);
    req[1].valid  = 1'b1;
    req[1].addr   = BASE + 64'h10;
    req[1].strobe = 8'hFF;
    req[1].data   = 64'h5555_6666_7777_8888;
    repeat (2) @(negedge clk);
    req[1].valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idle", 64'(u_dut1.state_q), 64'(IDLE));
    check("hold_data", resp[1].data, 64'h0101_0202_0303_0404);
    do_req(1, BASE + 64'h10, 8'h00, 64'h0, 1'b1, 64'h0101_0202_0303_0404);

    // Asynchronous reset mid-WAIT of a write
    do_req(1, BASE + 64'h18, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 64'd0);
    do_req(1, BASE + 64'h18, 8'h00, 64'h0, 1'b1, 64'h0F0E_0D0C_0B0A_0908);
    @(negedge clk);
    req[1].valid  = 1'b1;
    req[1].addr   = BASE + 64'h18;
    req[1].strobe = 8'hFF;
    req[1].data   = 64'hFFFF_EEEE_DDDD_CCCC;
    repeat (2) @(negedge clk);
    #2 rst[1] = 1'b1;
    #1;
    check("arst_addr_ok", 64'(resp[1].addr_ok), 64'd0);
    check("arst_data_ok", 64'(resp[1].data_ok), 64'd0);
    check("arst_data", resp[1].data, 64'd0);
    req[1].valid = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    do_req(1, BASE + 64'h18, 8'h00, 64'h0, 1'b1, 64'h0F0E_0D0C_0B0A_0908);
    do_req(1, BASE + 64'h10, 8'h00, 64'h0, 1'b1, 64'h0101_0202_0303_0404);

    // Back-to-back alternating writes and reads against a model (LATENCY=1)
    for (int k = 0; k < 8; k++) begin
      idx  = $urandom_range(0, 63);
      d    = {$urandom, $urandom};
      have = written[idx];
      old  = model[idx];
      do_req(2, BASE + 64'(idx * 8), 8'hFF, d, have, old);
      model[idx] = d;
      if (!written[idx]) wl.push_back(idx);
      written[idx] = 1'b1;
      r = (k % 2 == 0) ? idx : wl[$urandom_range(0, wl.size() - 1)];
      do_req(2, BASE + 64'(r * 8) + 64'($urandom_range(0, 7)), 8'h00, 64'h0, 1'b1, model[r]);
    end

    repeat (6) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dbus_ram_responder.md
DBUS_RAM_RESPONDER -- requirements
Module: dbus_ram_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, meaning the number of 64-bit words in the array (power of two).
REQ-002 The block SHALL have parameter BASE, default 64'h8000_0000, meaning the byte address of word 0.
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning the cycles from request to response (legal range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port dreq, input, dbus_req_t: fields valid, addr (64), size (msize_t), strobe (8), data (64).
REQ-007 The block SHALL have port dresp, output, dbus_resp_t: fields addr_ok, data_ok, data (64).

Function
REQ-008 The FSM SHALL have states IDLE, WAIT and RESP, with reset state IDLE.
REQ-009 In IDLE with dreq.valid=1, the block SHALL latch addr, strobe and data into request registers and count this cycle as cycle 0.
REQ-010 If LATENCY=1, IDLE+valid SHALL go to RESP; otherwise it SHALL go to WAIT with the down-counter loaded to LATENCY-2.
REQ-011 WAIT SHALL decrement the counter and SHALL go to RESP when the counter is 0 and valid is still 1.
REQ-012 If dreq.valid drops in WAIT, the request SHALL be aborted: next state IDLE, no write, and no response.
REQ-013 dresp.addr_ok and dresp.data_ok SHALL both equal (state==RESP), be high for exactly one cycle (cycle LATENCY), and be 0 in every other state.
REQ-014 RESP SHALL always go to IDLE; the next request SHALL be accepted no earlier than cycle LATENCY+1.
REQ-015 Requests SHALL use only the latched fields; changes on dreq after cycle 0 other than valid SHALL be ignored.
REQ-016 Word index SHALL be (addr-BASE)>>3, truncated to log2(MEM_WORDS) bits; addr[2:0] SHALL be ignored because lane placement is done by the initiator.
REQ-017 An address is in range iff BASE <= addr < BASE + 8*MEM_WORDS.
REQ-018 dresp.data SHALL be registered: on entry to RESP it SHALL load the full 64-bit word at the index as it stood before this request's write, or 0 if the address is out of range.
REQ-019 At the clock edge ending RESP, each byte i SHALL be written with data[8i+7:8i] where strobe[i]=1; strobe=0 is a read.
REQ-020 Writes to out-of-range addresses SHALL be dropped, but the request SHALL still receive its response.
REQ-021 size SHALL not alter behaviour; strobe alone defines the write bytes.
REQ-022 For back-to-back requests, a read following a write to the same word SHALL return the written value.
REQ-023 When dresp.data_ok=0, dresp.data SHALL hold its last value, and SHALL be 0 after reset.

Reset
REQ-024 Assertion of reset SHALL asynchronously set state=IDLE, counter=0, request registers=0 and dresp.data=0, and SHALL force addr_ok=data_ok=0.
REQ-025 Reset in WAIT or RESP SHALL abandon the request, so that no write is committed.
REQ-026 The memory array SHALL not be reset, and its contents SHALL survive reset.

Structure
REQ-027 dbus_req_t, dbus_resp_t and msize_t SHALL be reused from package common.
REQ-028 A responder state enum (IDLE/WAIT/RESP) SHALL be added to common.
REQ-029 One sub-module SHALL exist, byte_ram: a MEM_WORDS x 64 array with one synchronous read port and a byte-strobed write port.
REQ-030 The top level SHALL contain the FSM, counter, request registers and range decode.

Verification
REQ-031 Test: LATENCY=2, write addr 0x8000_0008, strobe 0xFF, data 0x1122334455667788, held valid -> data_ok high in cycle 2 only; a following read of 0x8000_0008 returns 0x1122334455667788 in its cycle 2.
REQ-032 Test: partial write strobe 0x0F, data 0xAAAAAAAA_BBBBBBBB over word 0x1122334455667788 -> a subsequent read returns 0x11223344_BBBBBBBB.
REQ-033 Test: read of 0x0000_1000 (below BASE) and write to BASE+8*MEM_WORDS -> both get data_ok; the read returns 0 and no array word changes.
REQ-034 Test: LATENCY=4, valid dropped in cycle 2 of a write -> data_ok never asserts, state returns to IDLE, and the word is unchanged.
REQ-035 Test: reset pulsed asynchronously mid-WAIT of a write -> addr_ok/data_ok go to 0 immediately, the write is not committed, and prior array contents remain readable after reset.
REQ-036 Test: LATENCY=1, 16 back-to-back alternating writes and reads of random words -> each response arrives 1 cycle after valid, and reads match a reference model.
